// File: rtl/opb_cmd_master_if.sv
// opb_cmd_master_if: command, response and OPB bus signals of the OPB command master
// master modport: the initiator (accepts cmd_*, drives OPB_* strobes, returns rsp_*)
// slave modport: host plus register-slave side
interface opb_cmd_master_if #(parameter int ADDR_W = 4);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [15:0]       cmd_wdata;
  logic [15:0]       cmd_mask;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              busy;
  logic [ADDR_W-1:0] OPB_ADDR;
  logic [15:0]       OPB_DI;
  logic              OPB_WE;
  logic              OPB_RE;
  logic [31:0]       OPB_DO;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_mask, rsp_ready, OPB_DO,
    output cmd_ready, rsp_valid, rsp_rdata, busy, OPB_ADDR, OPB_DI, OPB_WE, OPB_RE
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_mask, rsp_ready, OPB_DO,
    input  cmd_ready, rsp_valid, rsp_rdata, busy, OPB_ADDR, OPB_DI, OPB_WE, OPB_RE
  );
endinterface

// File: rtl/opb_cmd_master.sv
// opb_cmd_master: runs one OPB read, write or masked read-modify-write per host command
// OPB_CLK/OPB_RSTb: clock and synchronous active-low reset
// b: command port (valid/ready), buffered response port (valid/ready), OPB bus strobes
module opb_cmd_master #(
  parameter int RD_WAIT = 1,
  parameter int ADDR_W  = 4
) (
  input logic                OPB_CLK,
  input logic                OPB_RSTb,
  opb_cmd_master_if.master   b
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic [ADDR_W-1:0] addr, addr_n, opb_addr_n;
  logic [15:0]       wdata, wdata_n, mask, mask_n, opb_di_n;
  logic              rmw, rmw_n, we_n, re_n, rsp_valid_n, plain;
  logic [31:0]       rdata_n;
  assign plain = b.cmd_write && b.cmd_mask == 16'hFFFF;
  // Every bus output is computed one cycle ahead and registered, so the strobes
  // and address are glitch-free for the slaves' falling-edge write sampling.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    addr_n      = addr;
    wdata_n     = wdata;
    mask_n      = mask;
    rmw_n       = rmw;
    opb_addr_n  = '0;
    opb_di_n    = '0;
    we_n        = 1'b0;
    re_n        = 1'b0;
    rsp_valid_n = 1'b0;
    rdata_n     = b.rsp_rdata;
    case (state)
      IDLE: if (b.cmd_valid && b.cmd_ready) begin
        addr_n     = b.cmd_addr;
        wdata_n    = b.cmd_wdata;
        mask_n     = b.cmd_mask;
        rmw_n      = b.cmd_write && !plain;
        cnt_n      = 4'(RD_WAIT);
        rdata_n    = '0;
        state_n    = plain ? WRITE : READ;
        opb_addr_n = b.cmd_addr;
        we_n       = plain;
        re_n       = !plain;
        opb_di_n   = plain ? b.cmd_wdata : 16'h0;
      end
      READ: if (cnt == 4'd0) begin
        rdata_n     = b.OPB_DO;
        state_n     = rmw ? WRITE : RESP;
        we_n        = rmw;
        rsp_valid_n = !rmw;
        opb_addr_n  = rmw ? addr : '0;
        // Merge uses the live bus data, since rsp_rdata only updates at this same edge.
        opb_di_n    = rmw ? (b.OPB_DO[15:0] & ~mask) | (wdata & mask) : 16'h0;
      end else begin
        cnt_n      = cnt - 4'd1;
        re_n       = 1'b1;
        opb_addr_n = addr;
      end
      WRITE: begin
        state_n     = RESP;
        rsp_valid_n = 1'b1;
      end
      RESP: begin
        state_n     = b.rsp_ready ? IDLE : RESP;
        rsp_valid_n = !b.rsp_ready;
      end
    endcase
  end
  always_ff @(posedge OPB_CLK) begin
    if (!OPB_RSTb) begin
      state       <= IDLE;
      cnt         <= '0;
      addr        <= '0;
      wdata       <= '0;
      mask        <= '0;
      rmw         <= 1'b0;
      b.cmd_ready <= 1'b0;
      b.busy      <= 1'b0;
      b.OPB_ADDR  <= '0;
      b.OPB_DI    <= '0;
      b.OPB_WE    <= 1'b0;
      b.OPB_RE    <= 1'b0;
      b.rsp_valid <= 1'b0;
      b.rsp_rdata <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      addr        <= addr_n;
      wdata       <= wdata_n;
      mask        <= mask_n;
      rmw         <= rmw_n;
      b.cmd_ready <= state_n == IDLE;
      b.busy      <= state_n != IDLE;
      b.OPB_ADDR  <= opb_addr_n;
      b.OPB_DI    <= opb_di_n;
      b.OPB_WE    <= we_n;
      b.OPB_RE    <= re_n;
      b.rsp_valid <= rsp_valid_n;
      b.rsp_rdata <= rdata_n;
    end
  end
endmodule

// File: tb/tb_opb_cmd_master.sv
// tb_opb_cmd_master: table-driven scoreboard bench for opb_cmd_master (RD_WAIT 1 and 3)
module tb_opb_cmd_master;
  logic clk = 1'b0;
  logic rst1, rst3;
  always #5 clk = ~clk;
  opb_cmd_master_if #(.ADDR_W(4)) i1();
  opb_cmd_master_if #(.ADDR_W(4)) i3();
  opb_cmd_master #(.RD_WAIT(1), .ADDR_W(4)) u1 (.OPB_CLK(clk), .OPB_RSTb(rst1), .b(i1));
  opb_cmd_master #(.RD_WAIT(3), .ADDR_W(4)) u3 (.OPB_CLK(clk), .OPB_RSTb(rst3), .b(i3));
  logic [31:0] mem1 [16];
  logic [31:0] mem3 [16];
  assign i1.OPB_DO = mem1[i1.OPB_ADDR];
  assign i3.OPB_DO = mem3[i3.OPB_ADDR];
  always @(negedge clk) if (i1.OPB_WE) mem1[i1.OPB_ADDR][15:0] <= i1.OPB_DI;
  always @(negedge clk) if (i3.OPB_WE) mem3[i3.OPB_ADDR][15:0] <= i3.OPB_DI;
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q [$];
  typedef struct {
    logic        w;
    logic [3:0]  a;
    logic [15:0] d, m, edi;
    logic [31:0] er;
    int          ere, ewe, elat;
  } vec_t;
  vec_t tbl [9];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic do_cmd(input vec_t v, input int idx);
    int re_c, we_c, lat, bad;
    logic [15:0] di;
    re_c = 0; we_c = 0; lat = 0; bad = 0; di = '0;
    i1.cmd_write = v.w; i1.cmd_addr = v.a; i1.cmd_wdata = v.d; i1.cmd_mask = v.m;
    i1.cmd_valid = 1'b1; i1.rsp_ready = 1'b1;
    for (int t = 0; t < 20 && !i1.cmd_ready; t++) @(negedge clk);
    chk($sformatf("v%0d accept", idx), i1.cmd_ready, 1);
    exp_q.push_back(v.er);
    @(posedge clk); #1 i1.cmd_valid = 1'b0;
    for (int k = 1; k <= 30 && lat == 0; k++) begin
      @(negedge clk);
      if (i1.OPB_RE) begin re_c++; if (i1.OPB_ADDR != v.a) bad++; end
      if (i1.OPB_WE) begin we_c++; di = i1.OPB_DI; if (i1.OPB_ADDR != v.a) bad++; end
      if (i1.OPB_RE && i1.OPB_WE) bad++;
      if (i1.rsp_valid) begin
        lat = k;
        if (exp_q.size() > 0) chk($sformatf("v%0d rdata", idx), i1.rsp_rdata, exp_q.pop_front());
      end
    end
    chk($sformatf("v%0d latency", idx), lat, v.elat);
    chk($sformatf("v%0d re_cycles", idx), re_c, v.ere);
    chk($sformatf("v%0d we_cycles", idx), we_c, v.ewe);
    chk($sformatf("v%0d strobe_addr_errs", idx), bad, 0);
    if (v.ewe != 0) chk($sformatf("v%0d opb_di", idx), di, v.edi);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int re_c, lat, cnt_bad;
    for (int i = 0; i < 16; i++) begin mem1[i] = 32'h0; mem3[i] = 32'h0; end
    mem1[13] = 32'h0000_07D0;
    mem1[5]  = 32'hABCD_1234;
    mem3[2]  = 32'h0000_2222;
    mem3[3]  = 32'h0000_1111;
    tbl[0] = '{1'b1, 4'h1, 16'h003C, 16'hFFFF, 16'h003C, 32'h0000_0000, 0, 1, 2};
    tbl[1] = '{1'b0, 4'h1, 16'h0000, 16'h0000, 16'h0000, 32'h0000_003C, 2, 0, 3};
    tbl[2] = '{1'b0, 4'hD, 16'h0000, 16'h0000, 16'h0000, 32'h0000_07D0, 2, 0, 3};
    tbl[3] = '{1'b1, 4'hC, 16'h0055, 16'hFFFF, 16'h0055, 32'h0000_0000, 0, 1, 2};
    tbl[4] = '{1'b1, 4'hC, 16'h00F0, 16'h00F0, 16'h00F5, 32'h0000_0055, 2, 1, 4};
    tbl[5] = '{1'b0, 4'hC, 16'h0000, 16'h0000, 16'h0000, 32'h0000_00F5, 2, 0, 3};
    tbl[6] = '{1'b1, 4'h5, 16'hFFFF, 16'h0F0F, 16'h1F3F, 32'hABCD_1234, 2, 1, 4};
    tbl[7] = '{1'b0, 4'h5, 16'h0000, 16'h0000, 16'h0000, 32'hABCD_1F3F, 2, 0, 3};
    tbl[8] = '{1'b1, 4'h1, 16'hFFFF, 16'h0000, 16'h003C, 32'h0000_003C, 2, 1, 4};
    rst1 = 1'b0; rst3 = 1'b0;
    i1.cmd_valid = 1'b1; i1.cmd_write = 1'b1; i1.cmd_addr = 4'h7; i1.cmd_wdata = 16'hFFFF; i1.cmd_mask = 16'hFFFF; i1.rsp_ready = 1'b0;
    i3.cmd_valid = 1'b1; i3.cmd_write = 1'b1; i3.cmd_addr = 4'h7; i3.cmd_wdata = 16'hFFFF; i3.cmd_mask = 16'hFFFF; i3.rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst cmd_ready", i1.cmd_ready, 0);
      chk("rst strobes", {i1.OPB_WE, i1.OPB_RE}, 0);
      chk("rst rsp_valid", i1.rsp_valid, 0);
      chk("rst busy", i1.busy, 0);
      chk("rst3 cmd_ready", i3.cmd_ready, 0);
    end
    chk("rst opb_addr_di", {i1.OPB_ADDR, i1.OPB_DI}, 0);
    chk("rst rsp_rdata", i1.rsp_rdata, 0);
    rst1 = 1'b1; rst3 = 1'b1; i1.cmd_valid = 1'b0; i3.cmd_valid = 1'b0;
    @(negedge clk);
    chk("release cmd_ready", i1.cmd_ready, 1);
    chk("release3 cmd_ready", i3.cmd_ready, 1);
    for (int i = 0; i < 9; i++) do_cmd(tbl[i], i);
    chk("slave reg1 after write", mem1[1], 32'h0000_003C);
    @(negedge clk);
    i1.cmd_write = 1'b0; i1.cmd_addr = 4'hD; i1.cmd_valid = 1'b1; i1.rsp_ready = 1'b0;
    for (int t = 0; t < 20 && !i1.cmd_ready; t++) @(negedge clk);
    chk("bp accept", i1.cmd_ready, 1);
    @(posedge clk); #1;
    i1.cmd_write = 1'b1; i1.cmd_addr = 4'h2; i1.cmd_wdata = 16'h1234; i1.cmd_mask = 16'hFFFF;
    for (int t = 0; t < 20 && !i1.rsp_valid; t++) @(negedge clk);
    chk("bp rsp_valid arrives", i1.rsp_valid, 1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp rsp_valid hold", i1.rsp_valid, 1);
      chk("bp rsp_rdata hold", i1.rsp_rdata, 32'h0000_07D0);
      chk("bp cmd_ready", i1.cmd_ready, 0);
      chk("bp strobes", {i1.OPB_WE, i1.OPB_RE}, 0);
      chk("bp busy", i1.busy, 1);
    end
    i1.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp released rsp_valid", i1.rsp_valid, 0);
    chk("bp released cmd_ready", i1.cmd_ready, 1);
    chk("bp released busy", i1.busy, 0);
    @(posedge clk); #1 i1.cmd_valid = 1'b0;
    @(negedge clk);
    chk("bp next we", i1.OPB_WE, 1);
    chk("bp next addr", i1.OPB_ADDR, 4'h2);
    chk("bp next di", i1.OPB_DI, 16'h1234);
    @(negedge clk);
    chk("bp next rsp_valid", i1.rsp_valid, 1);
    chk("bp next rdata", i1.rsp_rdata, 0);
    @(negedge clk);
    chk("bp slave reg2", mem1[2], 32'h0000_1234);
    i3.cmd_write = 1'b0; i3.cmd_addr = 4'h2; i3.cmd_valid = 1'b1; i3.rsp_ready = 1'b1;
    re_c = 0; lat = 0;
    @(posedge clk); #1 i3.cmd_valid = 1'b0;
    for (int k = 1; k <= 30 && lat == 0; k++) begin
      @(negedge clk);
      if (i3.OPB_RE) re_c++;
      if (i3.rsp_valid) begin lat = k; chk("w3 read rdata", i3.rsp_rdata, 32'h0000_2222); end
    end
    chk("w3 read latency", lat, 5);
    chk("w3 read re_cycles", re_c, 4);
    @(negedge clk);
    i3.cmd_write = 1'b1; i3.cmd_addr = 4'h3; i3.cmd_wdata = 16'hFFFF; i3.cmd_mask = 16'h00FF; i3.cmd_valid = 1'b1;
    chk("w3 rmw ready", i3.cmd_ready, 1);
    @(posedge clk); #1 i3.cmd_valid = 1'b0;
    @(negedge clk);
    chk("w3 rmw re1", i3.OPB_RE, 1);
    @(negedge clk);
    chk("w3 rmw re2", i3.OPB_RE, 1);
    rst3 = 1'b0;
    @(negedge clk);
    chk("w3 reset re", i3.OPB_RE, 0);
    chk("w3 reset rsp_valid", i3.rsp_valid, 0);
    rst3 = 1'b1;
    cnt_bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (i3.OPB_WE || i3.OPB_RE || i3.rsp_valid) cnt_bad++;
    end
    chk("w3 post-reset activity", cnt_bad, 0);
    chk("w3 post-reset cmd_ready", i3.cmd_ready, 1);
    chk("w3 reg3 untouched", mem3[3], 32'h0000_1111);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
